// File: rtl/kws_frame_scheduler.sv
// KWS frame scheduler: writes audio into a circular buffer, tracks
// overlapping frames and sequences the CNN accelerator start/done handshake.
module kws_frame_scheduler #(
  parameter int FRAME_LEN   = 256,
  parameter int HOP_LEN     = 128,
  parameter int BUF_DEPTH   = 1024,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         clr_err,
  input  logic [15:0]                  audio_sample,
  input  logic                         sample_valid,
  output logic                         wr_en,
  output logic [$clog2(BUF_DEPTH)-1:0] wr_addr,
  output logic [15:0]                  wr_data,
  output logic                         accel_start,
  output logic [$clog2(BUF_DEPTH)-1:0] frame_base,
  input  logic                         accel_done,
  output logic                         busy,
  output logic                         irq,
  output logic [15:0]                  frame_count,
  output logic [7:0]                   overrun_count,
  output logic                         timeout_err
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int FW = $clog2(FRAME_LEN + 1);
  localparam int HW = $clog2(HOP_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [FW-1:0] FL   = FW'(FRAME_LEN);
  localparam logic [HW-1:0] HL   = HW'(HOP_LEN);
  localparam logic [TW-1:0] TL   = TW'(TIMEOUT_CYC - 1);
  localparam logic [AW-1:0] BOFF = AW'(FRAME_LEN % BUF_DEPTH);

  typedef enum logic [1:0] {
    S_DIS,
    S_ARM,
    S_RUN
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [AW-1:0] r_wptr;
  logic [FW-1:0] r_fill_cnt;
  logic [HW-1:0] r_hop_cnt;
  logic          r_pending;
  logic [AW-1:0] r_pend_base;

  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [15:0]   r_wr_data;
  logic          r_accel_start;
  logic [AW-1:0] r_frame_base;
  logic          r_irq;
  logic [15:0]   r_frame_count;
  logic [7:0]    r_overrun_count;
  logic          r_timeout_err;
  logic [TW-1:0] r_wdog;

  logic          w_acc;
  logic          w_filling;
  logic          w_evt;
  logic          w_ovr;
  logic [AW-1:0] w_wptr_nxt;
  logic          w_take;
  logic          w_done;
  logic          w_tmo;

  assign w_acc      = enable & sample_valid;
  assign w_filling  = (r_fill_cnt != FL);
  assign w_wptr_nxt = r_wptr + AW'(1);

  // Before the first frame the fill count decides; afterwards the hop count.
  assign w_evt = w_acc & (w_filling ? (r_fill_cnt + FW'(1) == FL)
                                    : (r_hop_cnt + HW'(1) == HL));

  // The frame being launched this cycle is not counted as dropped.
  assign w_ovr = w_evt & r_pending & ~w_take;

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    if (!enable) begin
      w_state_nxt = S_DIS;
    end else begin
      unique case (r_state)
        S_DIS: w_state_nxt = S_ARM;
        S_ARM: begin
          if (r_pending) begin
            w_take      = 1'b1;
            w_state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (accel_done) begin
            w_done      = 1'b1;
            w_state_nxt = S_ARM;
          end else if (r_wdog == TL) begin
            w_tmo       = 1'b1;
            w_state_nxt = S_ARM;
          end
        end
        default: w_state_nxt = S_DIS;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_fill_cnt  <= '0;
      r_hop_cnt   <= '0;
      r_pending   <= 1'b0;
      r_pend_base <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else if (!enable) begin
      r_wptr     <= '0;
      r_fill_cnt <= '0;
      r_hop_cnt  <= '0;
      r_pending  <= 1'b0;
      r_wr_en    <= 1'b0;
    end else begin
      r_wr_en <= w_acc;
      if (w_acc) begin
        r_wr_addr <= r_wptr;
        r_wr_data <= audio_sample;
        r_wptr    <= w_wptr_nxt;
        if (w_filling) r_fill_cnt <= r_fill_cnt + FW'(1);
        r_hop_cnt <= (w_evt || w_filling) ? '0 : r_hop_cnt + HW'(1);
      end
      if (w_evt) begin
        r_pending   <= 1'b1;
        r_pend_base <= w_wptr_nxt - BOFF;
      end else if (w_take) begin
        r_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_DIS;
      r_accel_start   <= 1'b0;
      r_frame_base    <= '0;
      r_irq           <= 1'b0;
      r_frame_count   <= '0;
      r_overrun_count <= '0;
      r_timeout_err   <= 1'b0;
      r_wdog          <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_accel_start <= w_take;
      r_irq         <= w_done;
      if (w_take) r_frame_base <= r_pend_base;
      if (r_state == S_RUN && w_state_nxt == S_RUN)
        r_wdog <= r_wdog + TW'(1);
      else
        r_wdog <= '0;
      if (w_done) r_frame_count <= r_frame_count + 16'd1;
      if (clr_err) begin
        r_overrun_count <= '0;
        r_timeout_err   <= 1'b0;
      end else begin
        if (w_tmo) r_timeout_err <= 1'b1;
        if (w_ovr && r_overrun_count != 8'hFF)
          r_overrun_count <= r_overrun_count + 8'd1;
      end
    end
  end

  assign wr_en         = r_wr_en;
  assign wr_addr       = r_wr_addr;
  assign wr_data       = r_wr_data;
  assign accel_start   = r_accel_start;
  assign frame_base    = r_frame_base;
  assign busy          = (r_state == S_RUN);
  assign irq           = r_irq;
  assign frame_count   = r_frame_count;
  assign overrun_count = r_overrun_count;
  assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_kws_frame_scheduler.sv
// Directed bench for kws_frame_scheduler (FRAME_LEN=8, HOP_LEN=4,
// BUF_DEPTH=16, TIMEOUT_CYC=64).
module tb_kws_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        clr_err = 1'b0;
  logic [15:0] audio_sample = '0;
  logic        sample_valid = 1'b0;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        accel_start;
  logic [3:0]  frame_base;
  logic        accel_done = 1'b0;
  logic        busy;
  logic        irq;
  logic [15:0] frame_count;
  logic [7:0]  overrun_count;
  logic        timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_wa  = 0;
  int exp_fc  = 0;
  int smp     = 0;

  kws_frame_scheduler #(
    .FRAME_LEN(8),
    .HOP_LEN(4),
    .BUF_DEPTH(16),
    .TIMEOUT_CYC(64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .clr_err(clr_err),
    .audio_sample(audio_sample),
    .sample_valid(sample_valid),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .accel_start(accel_start),
    .frame_base(frame_base),
    .accel_done(accel_done),
    .busy(busy),
    .irq(irq),
    .frame_count(frame_count),
    .overrun_count(overrun_count),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic feed(input int n);
    logic [15:0] v;
    for (int i = 0; i < n; i++) begin
      v = 16'(32'hA000 + smp);
      sample_valid = 1'b1;
      audio_sample = v;
      step();
      sample_valid = 1'b0;
      n_tests++;
      if (wr_en !== 1'b1 || wr_addr !== 4'(exp_wa) || wr_data !== v) begin
        n_fail++;
        $display("FAIL write: en=%0b addr=%0d data=%h expected en=1 addr=%0d data=%h",
                 wr_en, wr_addr, wr_data, exp_wa, v);
      end
      n_tests++;
      if (accel_start !== 1'b0) begin
        n_fail++;
        $display("FAIL early_start: accel_start=%0b expected 0 at addr %0d",
                 accel_start, exp_wa);
      end
      exp_wa = (exp_wa + 1) % 16;
      smp++;
    end
  endtask

  task automatic expect_start(input int base);
    step();
    n_tests++;
    if (accel_start !== 1'b1 || frame_base !== 4'(base) || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start: start=%0b base=%0d busy=%0b expected 1 %0d 1",
               accel_start, frame_base, busy, base);
    end
  endtask

  task automatic finish_run(input int wait_cyc);
    repeat (wait_cyc) step();
    n_tests++;
    if (busy !== 1'b1 || accel_start !== 1'b0) begin
      n_fail++;
      $display("FAIL run_hold: busy=%0b start=%0b expected 1 0", busy, accel_start);
    end
    accel_done = 1'b1;
    step();
    accel_done = 1'b0;
    exp_fc++;
    n_tests++;
    if (irq !== 1'b1 || frame_count !== 16'(exp_fc) || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done: irq=%0b count=%0d busy=%0b expected 1 %0d 0",
               irq, frame_count, busy, exp_fc);
    end
    step();
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_pulse: irq=%0b expected 0", irq);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    n_tests++;
    if ({wr_en, wr_addr, wr_data, accel_start, frame_base, busy, irq,
         frame_count, overrun_count, timeout_err} !== '0) begin
      n_fail++;
      $display("FAIL reset: en=%0b addr=%0d start=%0b busy=%0b fc=%0d oc=%0d te=%0b expected all 0",
               wr_en, wr_addr, accel_start, busy, frame_count, overrun_count, timeout_err);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_first_frame();
    enable = 1'b1;
    feed(8);
    expect_start(0);
    step();
    n_tests++;
    if (accel_start !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_pulse: start=%0b busy=%0b expected 0 1", accel_start, busy);
    end
  endtask

  task automatic test_stream();
    finish_run(8);
    feed(4);
    expect_start(4);
    finish_run(2);
    feed(4);
    expect_start(8);
    finish_run(2);
    feed(4);
    expect_start(12);
    finish_run(2);
    feed(4);
    expect_start(0);
    finish_run(2);
  endtask

  task automatic test_overrun();
    feed(4);
    expect_start(4);
    feed(8);
    n_tests++;
    if (overrun_count !== 8'd1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun: count=%0d busy=%0b expected 1 1", overrun_count, busy);
    end
    accel_done = 1'b1;
    step();
    accel_done = 1'b0;
    exp_fc++;
    n_tests++;
    if (irq !== 1'b1 || frame_count !== 16'(exp_fc)) begin
      n_fail++;
      $display("FAIL overrun_done: irq=%0b count=%0d expected 1 %0d",
               irq, frame_count, exp_fc);
    end
    expect_start(12);
  endtask

  task automatic test_timeout();
    repeat (63) step();
    n_tests++;
    if (busy !== 1'b1 || timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wdog_early: busy=%0b te=%0b expected 1 0", busy, timeout_err);
    end
    step();
    n_tests++;
    if (timeout_err !== 1'b1 || busy !== 1'b0 || irq !== 1'b0 ||
        frame_count !== 16'(exp_fc)) begin
      n_fail++;
      $display("FAIL wdog: te=%0b busy=%0b irq=%0b fc=%0d expected 1 0 0 %0d",
               timeout_err, busy, irq, frame_count, exp_fc);
    end
    step();
    n_tests++;
    if (accel_start !== 1'b0 || overrun_count !== 8'd1 || timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL post_wdog: start=%0b oc=%0d te=%0b expected 0 1 1",
               accel_start, overrun_count, timeout_err);
    end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    n_tests++;
    if (timeout_err !== 1'b0 || overrun_count !== 8'd0) begin
      n_fail++;
      $display("FAIL clr_err: te=%0b oc=%0d expected 0 0", timeout_err, overrun_count);
    end
  endtask

  task automatic test_disable();
    feed(4);
    expect_start(0);
    step();
    enable = 1'b0;
    step();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL disable_busy: busy=%0b expected 0", busy);
    end
    accel_done   = 1'b1;
    sample_valid = 1'b1;
    step();
    accel_done   = 1'b0;
    sample_valid = 1'b0;
    n_tests++;
    if (irq !== 1'b0 || frame_count !== 16'(exp_fc) || wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL disabled_done: irq=%0b fc=%0d wr_en=%0b expected 0 %0d 0",
               irq, frame_count, wr_en, exp_fc);
    end
    enable = 1'b1;
    exp_wa = 0;
    feed(8);
    expect_start(0);
    finish_run(3);
  endtask

  task automatic test_reset_mid_run_and_simul();
    logic [15:0] v;
    feed(4);
    expect_start(4);
    step();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({wr_en, wr_addr, wr_data, accel_start, frame_base, busy, irq,
         frame_count, overrun_count, timeout_err} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: addr=%0d base=%0d busy=%0b fc=%0d expected all 0",
               wr_addr, frame_base, busy, frame_count);
    end
    step();
    step();
    n_tests++;
    if (accel_start !== 1'b0 || irq !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: start=%0b irq=%0b busy=%0b expected 0 0 0",
               accel_start, irq, busy);
    end
    rst_n  = 1'b1;
    exp_fc = 0;
    exp_wa = 0;
    step();
    feed(8);
    expect_start(0);
    feed(3);
    v = 16'(32'hA000 + smp);
    sample_valid = 1'b1;
    audio_sample = v;
    accel_done   = 1'b1;
    step();
    sample_valid = 1'b0;
    accel_done   = 1'b0;
    smp++;
    exp_fc++;
    n_tests++;
    if (wr_addr !== 4'd11 || irq !== 1'b1 || frame_count !== 16'(exp_fc) ||
        accel_start !== 1'b0 || overrun_count !== 8'd0) begin
      n_fail++;
      $display("FAIL simul: addr=%0d irq=%0b fc=%0d start=%0b oc=%0d expected 11 1 %0d 0 0",
               wr_addr, irq, frame_count, accel_start, overrun_count, exp_fc);
    end
    exp_wa = 12;
    expect_start(4);
    finish_run(2);
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_stream();
    test_overrun();
    test_timeout();
    test_disable();
    test_reset_mid_run_and_simul();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
